// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   localparam logic [1:0]  RESP_OKAY = 2'b00;
   localparam logic [31:0] INST_NOP  = 32'h0000_0013;
   localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one AR/R read at a time, hands words to decode.
// Define IFU_ACCESS_FAULT_EN to add out_fault and substitute a nop on non-OKAY read responses.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] araddr,
   output logic            arvalid,
   input  logic            arready,
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      rresp,
   input  logic            rvalid,
   output logic            rready,
   output logic [XLEN-1:0] out_inst,
   output logic [XLEN-1:0] out_pc,
   output logic            out_valid,
`ifdef IFU_ACCESS_FAULT_EN
   output logic            out_fault,
`endif
   input  logic            out_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [1:0]      dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
   // arvalid/araddr and out_valid/out_inst/out_pc stay stable until their transfer; only a
   // redirect may retract out_valid, never arvalid.

   state_t          state, state_n;
   logic [XLEN-1:0] pc, pc_n, pc_sel, pc_inc;
   logic            drop, drop_n;
   logic [XLEN-1:0] araddr_n, out_inst_n, out_pc_n;
   logic            arvalid_n, rready_n, out_valid_n;
`ifdef IFU_ACCESS_FAULT_EN
   logic            out_fault_n;
`else
   logic            unused_rresp;
   assign unused_rresp = ^rresp;
`endif

   assign pc_sel    = redirect_valid ? redirect_pc : pc;
   assign pc_inc    = pc + XLEN'(PC_STEP);
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE: state_n = S_REQ;
         S_REQ:  if (arready) state_n = S_RESP;
         S_RESP: if (rvalid) state_n = (drop || redirect_valid) ? S_REQ : S_OUT;
         S_OUT:  if (redirect_valid || out_ready) state_n = S_REQ;
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      pc_n        = pc;
      drop_n      = drop;
      araddr_n    = araddr;
      arvalid_n   = arvalid;
      rready_n    = rready;
      out_valid_n = out_valid;
      out_inst_n  = out_inst;
      out_pc_n    = out_pc;
`ifdef IFU_ACCESS_FAULT_EN
      out_fault_n = out_fault;
`endif
      if (redirect_valid) pc_n = redirect_pc;
      unique case (state)
         S_IDLE: begin
            arvalid_n = 1'b1;
            araddr_n  = pc_sel;
         end
         S_REQ: begin
            // An accepted request cannot be cancelled; a redirect just marks its beat stale.
            if (arready) begin
               arvalid_n = 1'b0;
               rready_n  = 1'b1;
               drop_n    = drop | redirect_valid;
            end else if (redirect_valid) begin
               drop_n = 1'b1;
            end
         end
         S_RESP: begin
            if (rvalid) begin
               rready_n = 1'b0;
               if (drop || redirect_valid) begin
                  drop_n    = 1'b0;
                  arvalid_n = 1'b1;
                  araddr_n  = pc_sel;
               end else begin
                  out_valid_n = 1'b1;
                  out_pc_n    = araddr;
`ifdef IFU_ACCESS_FAULT_EN
                  out_fault_n = (rresp != RESP_OKAY);
                  out_inst_n  = (rresp != RESP_OKAY) ? XLEN'(INST_NOP) : rdata;
`else
                  out_inst_n  = rdata;
`endif
               end
            end else if (redirect_valid) begin
               drop_n = 1'b1;
            end
         end
         S_OUT: begin
            if (redirect_valid) begin
               out_valid_n = 1'b0;
               arvalid_n   = 1'b1;
               araddr_n    = redirect_pc;
            end else if (out_ready) begin
               out_valid_n = 1'b0;
               pc_n        = pc_inc;
               arvalid_n   = 1'b1;
               araddr_n    = pc_inc;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= RESET_PC;
         drop      <= 1'b0;
         araddr    <= '0;
         arvalid   <= 1'b0;
         rready    <= 1'b0;
         out_valid <= 1'b0;
         out_inst  <= '0;
         out_pc    <= '0;
`ifdef IFU_ACCESS_FAULT_EN
         out_fault <= 1'b0;
`endif
      end else begin
         pc        <= pc_n;
         drop      <= drop_n;
         araddr    <= araddr_n;
         arvalid   <= arvalid_n;
         rready    <= rready_n;
         out_valid <= out_valid_n;
         out_inst  <= out_inst_n;
         out_pc    <= out_pc_n;
`ifdef IFU_ACCESS_FAULT_EN
         out_fault <= out_fault_n;
`endif
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: memory responder, architectural PC model checked every cycle, directed scenarios.
// Build with IFU_ACCESS_FAULT_EN defined to also cover out_fault.
module tb_ifu_fetch;
   import ifu_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] araddr, rdata, out_inst, out_pc, redirect_pc;
   logic        arvalid, arready, rvalid, rready, out_valid, out_ready, redirect_valid;
   logic [1:0]  rresp, dbg_state;
`ifdef IFU_ACCESS_FAULT_EN
   logic        out_fault;
`endif

   ifu_fetch #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .out_inst(out_inst), .out_pc(out_pc), .out_valid(out_valid),
`ifdef IFU_ACCESS_FAULT_EN
      .out_fault(out_fault),
`endif
      .out_ready(out_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // memory configuration, written by the directed sequence
   int          ar_delay = 0;
   int          r_delay = 0;
   logic        override_en = 1'b0;
   logic [31:0] override_val = '0;
   logic        err_en = 1'b0;
   logic [31:0] err_addr = '0;

   // logs of observed transfers
   logic [31:0] ar_log[$];
   logic [31:0] out_log[$];
   logic [31:0] inst_log[$];
   logic [31:0] fault_log[$];
   int          out_cyc[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ~a ^ 32'h1234_5678;
   endfunction

   function automatic logic [31:0] exp_inst(input logic [31:0] a);
`ifdef IFU_ACCESS_FAULT_EN
      if (err_en && a == err_addr) return INST_NOP;
`endif
      return mem_word(a);
   endfunction

   // pre-edge snapshot of everything crossing the DUT boundary
   int          cyc = 0;
   logic        s_rst, s_arvalid, s_arready, s_rvalid, s_rready, s_out_valid, s_out_ready, s_redirect;
   logic [31:0] s_araddr, s_redirect_pc, s_out_pc, s_out_inst;
   logic        s_out_fault;

   always @(posedge clk) begin
      cyc           <= cyc + 1;
      s_rst         <= rst;
      s_arvalid     <= arvalid;
      s_arready     <= arready;
      s_araddr      <= araddr;
      s_rvalid      <= rvalid;
      s_rready      <= rready;
      s_out_valid   <= out_valid;
      s_out_ready   <= out_ready;
      s_redirect    <= redirect_valid;
      s_redirect_pc <= redirect_pc;
      s_out_pc      <= out_pc;
      s_out_inst    <= out_inst;
`ifdef IFU_ACCESS_FAULT_EN
      s_out_fault   <= out_fault;
`else
      s_out_fault   <= 1'b0;
`endif
   end

   // architectural model + memory responder
   logic [31:0] m_pc = RESET_PC;
   logic        pend = 1'b0;
   logic [31:0] pend_addr = '0;
   int          ar_cnt = 0;
   int          r_cnt = 0;

   always @(negedge clk) begin
      if (s_rst) begin
         m_pc = RESET_PC;
         pend = 1'b0;
         ar_cnt = 0;
         r_cnt = 0;
         arready = 1'b0;
         rvalid = 1'b0;
         rdata = '0;
         rresp = 2'b00;
      end else begin
         if (s_out_valid && s_out_ready && !s_redirect) begin
            out_log.push_back(s_out_pc);
            inst_log.push_back(s_out_inst);
            fault_log.push_back({31'd0, s_out_fault});
            out_cyc.push_back(cyc);
         end
         if (s_redirect) m_pc = s_redirect_pc;
         else if (s_out_valid && s_out_ready) m_pc = m_pc + 32'd4;

         if (s_arvalid && !s_arready) begin
            check("ar_held_valid", 32'(arvalid), 32'd1);
            check("ar_held_addr", araddr, s_araddr);
         end else if (arvalid) begin
            check("ar_new_addr", araddr, m_pc);
            ar_log.push_back(araddr);
         end

         if (out_valid) begin
            check("out_pc", out_pc, m_pc);
            check("out_inst", out_inst, exp_inst(m_pc));
            check("out_excl", {30'd0, arvalid, rready}, 32'd0);
`ifdef IFU_ACCESS_FAULT_EN
            check("out_fault", 32'(out_fault), 32'(err_en && m_pc == err_addr));
`endif
         end else if (s_out_valid && !s_out_ready && !s_redirect) begin
            check("out_retracted", 32'(out_valid), 32'd1);
         end

         if (s_rvalid && s_rready) begin
            pend = 1'b0;
            override_en = 1'b0;
         end
         if (s_arvalid && s_arready) begin
            check("single_outstanding", 32'(pend), 32'd0);
            pend = 1'b1;
            pend_addr = s_araddr;
            r_cnt = r_delay;
            ar_cnt = 0;
         end

         if (arvalid && !pend) begin
            arready = (ar_cnt >= ar_delay);
            ar_cnt++;
         end else begin
            arready = 1'b0;
            ar_cnt = 0;
         end

         if (pend && r_cnt == 0) begin
            rvalid = 1'b1;
            rdata = override_en ? override_val : mem_word(pend_addr);
            rresp = (err_en && pend_addr == err_addr) ? 2'b10 : 2'b00;
         end else begin
            if (pend) r_cnt--;
            rvalid = 1'b0;
            rdata = '0;
            rresp = 2'b00;
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc = target;
      step();
      redirect_valid = 1'b0;
   endtask

   task automatic wait_ar(input int n);
      int b = 0;
      while (ar_log.size() < n && b < 200) begin step(); b++; end
      if (ar_log.size() < n) check("ar_timeout", 32'(ar_log.size()), 32'(n));
   endtask

   task automatic wait_out(input int n);
      int b = 0;
      while (out_log.size() < n && b < 200) begin step(); b++; end
      if (out_log.size() < n) check("out_timeout", 32'(out_log.size()), 32'(n));
   endtask

   // kind 0: rready, 1: out_valid, 2: stalled AR request
   task automatic wait_cond(input int kind);
      int  b = 0;
      logic hit = 1'b0;
      while (!hit && b < 200) begin
         case (kind)
            0: hit = rready;
            1: hit = out_valid;
            default: hit = arvalid && !arready;
         endcase
         if (!hit) begin step(); b++; end
      end
      if (!hit) check("cond_timeout", 32'(kind), 32'hFFFF_FFFF);
   endtask

   task automatic check_reset_outputs();
      check("rst_arvalid", 32'(arvalid), 32'd0);
      check("rst_rready", 32'(rready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_araddr", araddr, 32'd0);
      check("rst_out_inst", out_inst, 32'd0);
      check("rst_out_pc", out_pc, 32'd0);
`ifdef IFU_ACCESS_FAULT_EN
      check("rst_out_fault", 32'(out_fault), 32'd0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] stale;
      rst = 1'b1;
      out_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      repeat (3) step();
      check_reset_outputs();

      // streaming with zero-wait memory
      ar_log.delete();
      out_log.delete();
      rst = 1'b0;
      wait_out(3);
      check("t1_ar0", ar_log[0], 32'h8000_0000);
      check("t1_ar1", ar_log[1], 32'h8000_0004);
      check("t1_ar2", ar_log[2], 32'h8000_0008);
      check("t1_pc0", out_log[0], 32'h8000_0000);
      check("t1_pc2", out_log[2], 32'h8000_0008);
      check("t1_inst0", inst_log[0], 32'h6DCB_A987);
      check("t1_rate", 32'(out_cyc[2] - out_cyc[1]), 32'd3);

      // decode back-pressure
      out_ready = 1'b0;
      wait_cond(1);
      check("t2_pc", out_pc, 32'h8000_000C);
      check("t2_inst", out_inst, 32'h6DCB_A98B);
      repeat (5) step();
      check("t2_hold_valid", 32'(out_valid), 32'd1);
      check("t2_hold_pc", out_pc, 32'h8000_000C);
      check("t2_no_ar", 32'(arvalid), 32'd0);
      ar_log.delete();
      out_ready = 1'b1;
      wait_ar(1);
      check("t2_next_ar", ar_log[0], 32'h8000_0010);

      // redirect while waiting for R
      r_delay = 3;
      wait_cond(0);
      override_val = 32'hDEAD_BEEF;
      override_en = 1'b1;
      ar_log.delete();
      out_log.delete();
      inst_log.delete();
      pulse_redirect(32'h8000_0100);
      r_delay = 0;
      wait_ar(1);
      check("t3_ar", ar_log[0], 32'h8000_0100);
      wait_out(1);
      check("t3_pc", out_log[0], 32'h8000_0100);
      check("t3_inst", inst_log[0], 32'h6DCB_A887);

      // redirect while AR is stalled
      ar_delay = 4;
      wait_cond(2);
      stale = araddr;
      ar_log.delete();
      out_log.delete();
      pulse_redirect(32'h8000_0200);
      check("t4_stale_valid", 32'(arvalid), 32'd1);
      check("t4_stale_addr", araddr, stale);
      wait_ar(1);
      ar_delay = 0;
      check("t4_ar", ar_log[0], 32'h8000_0200);
      wait_out(1);
      check("t4_pc", out_log[0], 32'h8000_0200);

      // redirect coinciding with the decode transfer, then PC wrap
      wait_cond(1);
      ar_log.delete();
      out_log.delete();
      pulse_redirect(32'hFFFF_FFFC);
      wait_ar(2);
      check("t5_ar0", ar_log[0], 32'hFFFF_FFFC);
      check("t5_ar1", ar_log[1], 32'h0000_0000);
      wait_out(2);
      check("t5_pc0", out_log[0], 32'hFFFF_FFFC);
      check("t5_pc1", out_log[1], 32'h0000_0000);

      // error response on one beat
      err_addr = 32'h8000_0304;
      err_en = 1'b1;
      out_log.delete();
      inst_log.delete();
      fault_log.delete();
      pulse_redirect(32'h8000_0300);
      wait_out(3);
      check("t6_pc1", out_log[1], 32'h8000_0304);
`ifdef IFU_ACCESS_FAULT_EN
      check("t6_inst1", inst_log[1], 32'h0000_0013);
      check("t6_fault1", fault_log[1], 32'd1);
      check("t6_fault2", fault_log[2], 32'd0);
`else
      check("t6_inst1", inst_log[1], 32'h6DCB_AA83);
`endif
      check("t6_inst2", inst_log[2], 32'h6DCB_AA8F);
      err_en = 1'b0;

      // reset in the middle of a read
      r_delay = 2;
      wait_cond(0);
      rst = 1'b1;
      step();
      step();
      check_reset_outputs();
      ar_log.delete();
      out_log.delete();
      r_delay = 0;
      rst = 1'b0;
      wait_out(1);
      check("t7_ar", ar_log[0], RESET_PC);
      check("t7_pc", out_log[0], RESET_PC);

      step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
